// File: rtl/sd_dac_sequencer.sv
// Round-robin sequencer feeding two signed sample streams into a sigma-delta DAC.
// Each accepted sample is held for OSR clocks; switching channels first mutes din_o.
module sd_dac_sequencer #(
  parameter int WIDTH       = 16,
  parameter int OSR         = 64,
  parameter int MUTE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic [WIDTH-1:0] din_o,
  output logic             chan_o,
  output logic             busy,
  output logic             sample_done,
  output logic [1:0]       state_dbg
);

  localparam int MAXC = (OSR > MUTE_CYCLES) ? OSR : MUTE_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_INIT = CW'(OSR - 1);
  localparam logic [CW-1:0] MUTE_INIT = CW'(MUTE_CYCLES - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUTE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sbuf;
  logic             last;
  logic             grant;
  logic             idle_en;
  logic             xfer;
  logic [WIDTH-1:0] xdata;

  // The channel not served last wins a tie; last resets to 1 so channel 0 leads.
  always_comb begin
    grant = ~last;
    if (req0_valid && !req1_valid)
      grant = 1'b0;
    else if (req1_valid && !req0_valid)
      grant = 1'b1;
  end

  // Handshake: a sample moves on a rising clk edge where reqX_valid and
  // reqX_ready are both high; ready only rises in IDLE with en set, never in reset.
  assign idle_en    = (state == IDLE) && en && !rst;
  assign req0_ready = idle_en && !grant;
  assign req1_ready = idle_en && grant;
  assign xfer       = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  assign xdata      = grant ? req1_data : req0_data;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sbuf        <= '0;
      last        <= 1'b1;
      din_o       <= '0;
      chan_o      <= 1'b0;
      busy        <= 1'b0;
      sample_done <= 1'b0;
    end else begin
      sample_done <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            last <= grant;
            sbuf <= xdata;
            busy <= 1'b1;
            if (grant == chan_o) begin
              state <= HOLD;
              din_o <= xdata;
              cnt   <= HOLD_INIT;
            end else begin
              state  <= MUTE;
              din_o  <= '0;
              chan_o <= grant;
              cnt    <= MUTE_INIT;
            end
          end
        end
        MUTE: begin
          if (cnt == '0) begin
            state <= HOLD;
            din_o <= sbuf;
            cnt   <= HOLD_INIT;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        HOLD: begin
          // Raised one cycle early so the registered pulse lands on the final HOLD cycle.
          if (cnt == ONE)
            sample_done <= 1'b1;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dac_sequencer.sv
// Bench for sd_dac_sequencer: IDLE ready table, hold/mute timing sequences,
// and a sample scoreboard popped on every sample_done pulse.
module tb_sd_dac_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         v0 = 1'b0, v1 = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] din_o;
  logic         chan_o, busy, sample_done;
  logic [1:0]   state_dbg;

  logic         rst2 = 1'b1;
  logic         en2 = 1'b0;
  logic         v02 = 1'b0, v12 = 1'b0;
  logic [W-1:0] d02 = '0, d12 = '0;
  logic         r02, r12;
  logic [W-1:0] din2;
  logic         chan2, busy2, sd2;
  logic [1:0]   st2;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  sd_dac_sequencer #(.WIDTH(W), .OSR(64), .MUTE_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .din_o(din_o), .chan_o(chan_o), .busy(busy),
    .sample_done(sample_done), .state_dbg(state_dbg)
  );

  sd_dac_sequencer #(.WIDTH(W), .OSR(2), .MUTE_CYCLES(1)) u_small (
    .clk(clk), .rst(rst2), .en(en2),
    .req0_valid(v02), .req0_data(d02), .req0_ready(r02),
    .req1_valid(v12), .req1_data(d12), .req1_ready(r12),
    .din_o(din2), .chan_o(chan2), .busy(busy2),
    .sample_done(sd2), .state_dbg(st2)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  // scoreboard: every completed sample must match the next expected {chan, data}
  always @(negedge clk) begin
    if (!rst && sample_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h with nothing expected", {chan_o, din_o});
      end else begin
        chk("sb_sample", {chan_o, din_o}, exp_q.pop_front());
      end
    end
  end

  typedef struct {
    logic rst, en, v0, v1, r0, r1;
  } vec_t;
  vec_t vt[8];

  int e_st[10];
  logic [W-1:0] e_din[10];
  logic e_sd[10];

  int  done_n, zrun, mutes;
  logic sd_seen;

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // reset state
    do_reset();
    chk("rst_din", din_o, 0);
    chk("rst_chan", chan_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sample_done, 0);
    chk("rst_state", state_dbg, 0);

    // IDLE ready table; inputs are cleared before the next rising edge
    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst; en = vt[i].en; v0 = vt[i].v0; v1 = vt[i].v1;
      #1;
      chk("tbl_ready0", req0_ready, vt[i].r0);
      chk("tbl_ready1", req1_ready, vt[i].r1);
      #1;
      rst = 1'b0; en = 1'b0; v0 = 1'b0; v1 = 1'b0;
      @(negedge clk);
    end

    // single channel 0 sample: direct HOLD, 64 busy cycles
    do_reset();
    en = 1'b1; v0 = 1'b1; d0 = 16'h4000;
    #1;
    chk("a_ready0_first", req0_ready, 1);
    chk("a_ready1_first", req1_ready, 0);
    exp_q.push_back({1'b0, 16'h4000});
    @(negedge clk);
    v0 = 1'b0;
    chk("a_chan", chan_o, 0);
    chk("a_state_hold", state_dbg, 2);
    for (int k = 1; k <= 64; k++) begin
      chk("a_busy", busy, 1);
      chk("a_done", sample_done, (k == 64));
      chk("a_din", din_o, 16'h4000);
      @(negedge clk);
    end
    chk("a_busy_end", busy, 0);
    chk("a_din_kept", din_o, 16'h4000);
    wait_drain();

    // both channels continuously valid: alternate with 8-cycle mutes
    do_reset();
    en = 1'b1; v0 = 1'b1; v1 = 1'b1; d0 = 16'h4000; d1 = 16'hC000;
    exp_q.push_back({1'b0, 16'h4000});
    exp_q.push_back({1'b1, 16'hC000});
    exp_q.push_back({1'b0, 16'h4000});
    exp_q.push_back({1'b1, 16'hC000});
    done_n = 0; zrun = 0; mutes = 0;
    for (int c = 0; c < 600 && done_n < 4; c++) begin
      @(negedge clk);
      chk("b_chan_data", (din_o == '0) || (din_o == (chan_o ? d1 : d0)), 1);
      if (busy && din_o == '0) begin
        zrun++;
      end else begin
        if (zrun != 0) begin
          chk("b_mute_len", zrun, 8);
          mutes++;
        end
        zrun = 0;
      end
      if (sample_done) done_n++;
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("b_done_count", done_n, 4);
    chk("b_mutes", mutes, 3);
    wait_drain();

    // en dropped mid-HOLD: HOLD finishes, no acceptance until en returns
    do_reset();
    en = 1'b1; v0 = 1'b1; d0 = 16'h1234;
    exp_q.push_back({1'b0, 16'h1234});
    repeat (10) @(negedge clk);
    en = 1'b0;
    sd_seen = 1'b0;
    for (int c = 0; c < 100 && !sd_seen; c++) begin
      @(negedge clk);
      chk("c_ready0_en_low", req0_ready, 0);
      if (sample_done) sd_seen = 1'b1;
    end
    chk("c_sample_done", sd_seen, 1);
    repeat (3) begin
      @(negedge clk);
      chk("c_idle_ready0", req0_ready, 0);
      chk("c_idle_busy", busy, 0);
    end
    en = 1'b1;
    #1;
    chk("c_ready0_resume", req0_ready, 1);
    exp_q.push_back({1'b0, 16'h1234});
    @(negedge clk);
    v0 = 1'b0;
    chk("c_busy_resume", busy, 1);
    wait_drain();

    // asynchronous reset mid-HOLD, then pointer must favour channel 0 again
    do_reset();
    en = 1'b1; v0 = 1'b1; d0 = 16'h7FFF;
    #1;
    chk("d_ready0", req0_ready, 1);
    exp_q.push_back({1'b0, 16'h7FFF});
    @(negedge clk);
    v0 = 1'b0;
    chk("d_din_hold", din_o, 16'h7FFF);
    repeat (20) @(negedge clk);
    #2;
    v0 = 1'b1; v1 = 1'b1; rst = 1'b1;
    exp_q.delete();
    #1;
    chk("d_rst_din", din_o, 0);
    chk("d_rst_busy", busy, 0);
    chk("d_rst_state", state_dbg, 0);
    chk("d_rst_ready0", req0_ready, 0);
    chk("d_rst_ready1", req1_ready, 0);
    @(negedge clk);
    rst = 1'b0; d0 = 16'h1111; d1 = 16'h2222;
    #1;
    chk("d_post_ready0", req0_ready, 1);
    chk("d_post_ready1", req1_ready, 0);
    exp_q.push_back({1'b0, 16'h1111});
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    chk("d_post_din", din_o, 16'h1111);
    chk("d_post_state", state_dbg, 2);
    wait_drain();

    // OSR=2, MUTE_CYCLES=1, channel 1 only, negative full-scale sample
    e_st  = '{1, 2, 2, 0, 2, 2, 0, 2, 2, 0};
    e_din = '{16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
              16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    e_sd  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst2 = 1'b0; en2 = 1'b1; v12 = 1'b1; d12 = 16'h8000;
    #1;
    chk("e_ready1", r12, 1);
    chk("e_ready0", r02, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("e_state", st2, e_st[i]);
      chk("e_din", din2, e_din[i]);
      chk("e_done", sd2, e_sd[i]);
      chk("e_chan", chan2, 1);
    end
    v12 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
